// File: rtl/window_aggregator_if.sv
// Handshake and result bundle between the shift window, window_aggregator
// and the stream-evaluation stage.
// master: the environment (window producer plus result consumer).
// slave : window_aggregator.
interface window_aggregator_if #(
    parameter int DATA_W = 64
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] tap0;
    logic signed [DATA_W-1:0] tap1;
    logic signed [DATA_W-1:0] tap2;
    logic signed [DATA_W-1:0] tap3;
    logic signed [DATA_W-1:0] tap4;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] min;
    logic signed [DATA_W-1:0] max;
    logic [2:0]               count;
    logic                     overflow;

    modport master (
        output in_valid, tap0, tap1, tap2, tap3, tap4, out_ready,
        input  in_ready, out_valid, sum, min, max, count, overflow
    );

    modport slave (
        input  in_valid, tap0, tap1, tap2, tap3, tap4, out_ready,
        output in_ready, out_valid, sum, min, max, count, overflow
    );
endinterface

// File: rtl/window_aggregator.sv
// window_aggregator: snapshots the 5-tap shift window on each shift event,
// folds the filled taps one per cycle into sum/min/max/count and offers the
// result on a valid/ready handshake.
// Optional feature macro: WINDOW_AGG_SATURATE_EN -- clamp sum on overflow
// instead of two's-complement wrap.
module window_aggregator #(
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,   // synchronous, active-low
    input  logic                  en,
    window_aggregator_if.slave    bus
);
    localparam int ACC_W = DATA_W + 3;
    localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                   state_q;
    logic [2:0]               fill_q;
    logic [2:0]               idx_q;
    logic signed [DATA_W-1:0] snap_q [0:4];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] min_acc_q;
    logic signed [DATA_W-1:0] max_acc_q;
    logic signed [DATA_W-1:0] sum_q;
    logic signed [DATA_W-1:0] min_q;
    logic signed [DATA_W-1:0] max_q;
    logic [2:0]               count_q;
    logic                     ovf_q;
    logic                     out_valid_q;

    logic signed [DATA_W-1:0] tap_sel;
    logic                     fold;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [DATA_W-1:0] min_d;
    logic signed [DATA_W-1:0] max_d;
    logic                     ovf_d;
    logic signed [DATA_W-1:0] sum_d;
    logic [3:0]               acc_top;

    // Fold of the current slot plus range check and acc-to-sum conversion.
    always_comb begin
        tap_sel = snap_q[idx_q];
        fold    = (idx_q < fill_q);
        acc_d   = acc_q;
        min_d   = min_acc_q;
        max_d   = max_acc_q;
        if (fold) begin
            acc_d = acc_q + {{3{tap_sel[DATA_W-1]}}, tap_sel};
            if (tap_sel < min_acc_q) min_d = tap_sel;
            if (tap_sel > max_acc_q) max_d = tap_sel;
        end
        // acc fits in DATA_W bits only if its top 4 bits are sign copies.
        acc_top = acc_d[ACC_W-1:DATA_W-1];
        ovf_d   = (acc_top != 4'b0000) && (acc_top != 4'b1111);
`ifdef WINDOW_AGG_SATURATE_EN
        if (ovf_d) sum_d = acc_d[ACC_W-1] ? MIN_NEG : MAX_POS;
        else       sum_d = acc_d[DATA_W-1:0];
`else
        sum_d = acc_d[DATA_W-1:0];
`endif
    end

    // Control FSM with snapshot, accumulator and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            fill_q      <= 3'd0;
            idx_q       <= 3'd0;
            acc_q       <= '0;
            min_acc_q   <= '0;
            max_acc_q   <= '0;
            sum_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= 3'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 5; i++) snap_q[i] <= '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        snap_q[0] <= bus.tap0;
                        snap_q[1] <= bus.tap1;
                        snap_q[2] <= bus.tap2;
                        snap_q[3] <= bus.tap3;
                        snap_q[4] <= bus.tap4;
                        fill_q    <= (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
                        acc_q     <= '0;
                        min_acc_q <= MAX_POS;
                        max_acc_q <= MIN_NEG;
                        idx_q     <= 3'd0;
                        state_q   <= ACC;
                    end
                end
                ACC: begin
                    acc_q     <= acc_d;
                    min_acc_q <= min_d;
                    max_acc_q <= max_d;
                    if (idx_q == 3'd4) begin
                        idx_q       <= 3'd0;
                        sum_q       <= sum_d;
                        min_q       <= min_d;
                        max_q       <= max_d;
                        count_q     <= fill_q;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && en;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.min       = min_q;
    assign bus.max       = max_q;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
endmodule
